// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Scan controller that sits upstream of a 4:1 4-bit selector. It visits four input channels
//   in round-robin order and drives the selector's select lines. After a settle time it
//   captures the selector output and offers it downstream through a valid/ack handshake.
//
// Parameters
//   SETTLE_CYC  cycles the select is held before iZ is sampled (0 behaves as 1)
//   CNT_W       settle counter width, must hold SETTLE_CYC-1
//
// Ports
//   iClk    clock, rising edge
//   iRst    asynchronous active-high reset
//   iEn     scan enable, only looked at while idle
//   iReq    per-channel request, bit n = channel n
//   iZ      selector output fed back for capture
//   iAck    downstream accepts oData while oValid is high
//   oS1/oS0 select lines to the selector
//   oData   captured channel word
//   oCh     channel index of oData
//   oValid  oData/oCh valid
//   oBusy   high whenever a transaction is in flight
//
// Configuration
//   MUX_SCAN_SKIP_IDLE_EN: when defined, the idle state jumps straight to the first requested
//   channel at or after the pointer in one cycle. When undefined, it skips one channel per
//   cycle.

module mux_scan_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 4
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEn,
    input  logic [3:0] iReq,
    input  logic [3:0] iZ,
    input  logic       iAck,
    output logic       oS1,
    output logic       oS0,
    output logic [3:0] oData,
    output logic [1:0] oCh,
    output logic       oValid,
    output logic       oBusy
);

    localparam int SettleEff = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(SettleEff - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StPresent
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;

    // Grant decision for the idle state: whether a channel is granted and which one.
    logic       hit;
    logic [1:0] pick;

`ifdef MUX_SCAN_SKIP_IDLE_EN
    // Walk offsets from far to near so the nearest requested channel wins.
    always_comb begin
        hit  = 1'b0;
        pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (iReq[ptr + 2'(i)]) begin
                hit  = 1'b1;
                pick = ptr + 2'(i);
            end
        end
    end
`else
    always_comb begin
        hit  = iReq[ptr];
        pick = ptr;
    end
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state  <= StIdle;
            ptr    <= 2'd0;
            cnt    <= '0;
            oS1    <= 1'b0;
            oS0    <= 1'b0;
            oData  <= 4'd0;
            oCh    <= 2'd0;
            oValid <= 1'b0;
            oBusy  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (iEn) begin
                        if (hit) begin
                            {oS1, oS0} <= pick;
                            ptr        <= pick;
                            cnt        <= '0;
                            oBusy      <= 1'b1;
                            state      <= StSelect;
                        end else begin
`ifndef MUX_SCAN_SKIP_IDLE_EN
                            ptr <= ptr + 2'd1;
`endif
                        end
                    end
                end
                StSelect: begin
                    // Saturate so the counter can never wrap back below CntLast.
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (cnt == CntLast) begin
                        oData  <= iZ;
                        oCh    <= {oS1, oS0};
                        oValid <= 1'b1;
                        state  <= StPresent;
                    end
                end
                StPresent: begin
                    if (iAck) begin
                        oValid <= 1'b0;
                        oBusy  <= 1'b0;
                        ptr    <= oCh + 2'd1;
                        state  <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl
//   Randomized bench for mux_scan_ctrl with a transaction-level reference model and a
//   behavioural 4:1 selector closing the iZ feedback loop.

module tb_mux_scan_ctrl;

    localparam int Settle = 2;

    logic       iClk;
    logic       iRst;
    logic       iEn;
    logic [3:0] iReq;
    logic [3:0] iZ;
    logic       iAck;
    logic       oS1;
    logic       oS0;
    logic [3:0] oData;
    logic [1:0] oCh;
    logic       oValid;
    logic       oBusy;

    logic [3:0] chData [4];

    // Behavioural selector: the word of the selected channel.
    assign iZ = chData[{oS1, oS0}];

    mux_scan_ctrl #(
        .SETTLE_CYC(Settle),
        .CNT_W     (4)
    ) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iEn   (iEn),
        .iReq  (iReq),
        .iZ    (iZ),
        .iAck  (iAck),
        .oS1   (oS1),
        .oS0   (oS0),
        .oData (oData),
        .oCh   (oCh),
        .oValid(oValid),
        .oBusy (oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int nPass;
    int nChecks;

    task automatic checkVal(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: which channel is pointed at, how many settle cycles remain before
    // capture, and the word being offered downstream.
    int mPtr;
    int mSel;
    int mSettleLeft;
    int mData;
    int mCh;
    bit mValid;

    task automatic modelReset();
        mPtr = 0; mSel = 0; mSettleLeft = 0; mData = 0; mCh = 0; mValid = 0;
    endtask

    task automatic modelStep();
        int found;
        if (mValid) begin
            if (iAck) begin
                mValid = 0;
                mPtr   = (mCh + 1) % 4;
            end
        end else if (mSettleLeft > 0) begin
            mSettleLeft--;
            if (mSettleLeft == 0) begin
                mData  = int'(chData[mSel]);
                mCh    = mSel;
                mValid = 1;
            end
        end else if (iEn) begin
`ifdef MUX_SCAN_SKIP_IDLE_EN
            found = -1;
            for (int k = 0; k < 4; k++) begin
                if (found < 0 && iReq[(mPtr + k) % 4]) found = (mPtr + k) % 4;
            end
            if (found >= 0) begin
                mPtr = found; mSel = found; mSettleLeft = Settle;
            end
`else
            found = 0;
            if (iReq[mPtr]) begin
                mSel = mPtr; mSettleLeft = Settle;
            end else begin
                mPtr = (mPtr + 1) % 4;
            end
`endif
        end
    endtask

    task automatic checkAll();
        checkVal("sel",   int'({oS1, oS0}), mSel);
        checkVal("valid", int'(oValid), int'(mValid));
        checkVal("data",  int'(oData), mData);
        checkVal("ch",    int'(oCh), mCh);
        checkVal("busy",  int'(oBusy), int'(mValid || mSettleLeft > 0));
    endtask

    task automatic cycle();
        @(posedge iClk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic doReset();
        iRst = 1'b1;
        modelReset();
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        checkAll();
    endtask

    initial begin
        int grantEdge;
        bit reached;
        nPass = 0; nChecks = 0;
        iRst = 1'b1; iEn = 1'b0; iReq = 4'd0; iAck = 1'b0;
        for (int c = 0; c < 4; c++) chData[c] = 4'd0;
        modelReset();
        #12;
        checkVal("reset_valid", int'(oValid), 0);
        checkVal("reset_busy",  int'(oBusy), 0);
        doReset();

        // Single channel, ack tied high.
        chData[0] = 4'h5; iEn = 1'b1; iReq = 4'b0001; iAck = 1'b1;
        cycle(); checkVal("t2_sel", int'({oS1, oS0}), 0);
        checkVal("t2_busy", int'(oBusy), 1);
        cycle(); checkVal("t2_valid_early", int'(oValid), 0);
        cycle(); checkVal("t2_valid", int'(oValid), 1);
        checkVal("t2_data", int'(oData), 5);
        checkVal("t2_ch", int'(oCh), 0);
        cycle(); checkVal("t2_valid_drop", int'(oValid), 0);

        // Round robin with fixed channel words n+1.
        doReset();
        for (int c = 0; c < 4; c++) chData[c] = 4'(c + 1);
        iReq = 4'b1111;
        for (int w = 0; w < 5; w++) begin
            for (int e = 0; e < 2 + Settle; e++) cycle();
            // The fourth edge of each word is its ack edge; check the word just before it.
        end
        doReset();
        for (int w = 0; w < 5; w++) begin
            cycle(); cycle(); cycle();
            checkVal("t3_ch",   int'(oCh), w % 4);
            checkVal("t3_data", int'(oData), (w % 4) + 1);
            cycle();
        end

        // Sparse request: only channel 3.
        doReset();
        chData[3] = 4'hA; iReq = 4'b1000;
`ifdef MUX_SCAN_SKIP_IDLE_EN
        grantEdge = 1;
`else
        grantEdge = 4;
`endif
        for (int e = 1; e <= grantEdge; e++) begin
            cycle();
            if (e < grantEdge) checkVal("t5_idle_busy", int'(oBusy), 0);
        end
        checkVal("t5_sel", int'({oS1, oS0}), 3);
        checkVal("t5_busy", int'(oBusy), 1);

        // Request and enable withdrawn mid-transaction; the word still arrives.
        iReq = 4'd0; iEn = 1'b0;
        for (int e = 0; e < 8; e++) cycle();
        checkVal("t6_busy", int'(oBusy), 0);

        // Async reset in the middle of a presented word.
        doReset();
        iEn = 1'b1; iReq = 4'b1111; iAck = 1'b0;
        reached = 0;
        for (int e = 0; e < 20 && !reached; e++) begin
            cycle();
            if (oValid) reached = 1;
        end
        checkVal("t1_present", int'(oValid), 1);
        #2 iRst = 1'b1;
        #1;
        checkVal("t1_valid", int'(oValid), 0);
        checkVal("t1_busy",  int'(oBusy), 0);
        checkVal("t1_sel",   int'({oS1, oS0}), 0);
        checkVal("t1_data",  int'(oData), 0);
        checkVal("t1_ch",    int'(oCh), 0);
        modelReset();
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        checkAll();

        // Randomized phases with different request shapes and ack behaviour.
        for (int p = 0; p < 5; p++) begin
            for (int n = 0; n < 300; n++) begin
                iEn = ($urandom_range(0, 9) != 0);
                case (p)
                    0: iReq = 4'b1111;
                    1: iReq = 4'b1000;
                    2: iReq = 4'b0000;
                    default: iReq = 4'($urandom_range(0, 15));
                endcase
                iAck = (p == 4) ? 1'b1 : ($urandom_range(0, 9) < 4);
                for (int c = 0; c < 4; c++) chData[c] = 4'($urandom_range(0, 15));
                cycle();
            end
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
